// File: rtl/axis_out.sv
// AXI-Stream master output stage: buffers FIR results in a small FIFO and
// streams one frame of data_length samples, flagging tlast and reporting completion.
module axis_out #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pFIFO_DEPTH = 4,
  parameter int unsigned pLEN_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ap_start,
  input  logic [pLEN_WIDTH-1:0]  data_length,
  input  logic [pDATA_WIDTH-1:0] res_data,
  input  logic                   res_valid,
  output logic                   res_ready,
  output logic                   tvalid,
  output logic [pDATA_WIDTH-1:0] tdata,
  output logic                   tlast,
  input  logic                   tready,
  output logic                   axis_finish,
  output logic                   busy
);

  localparam int unsigned AW = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [pLEN_WIDTH-1:0]   len_q, len_d;
  logic [pLEN_WIDTH-1:0]   in_cnt_q, in_cnt_d;
  logic [pLEN_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [pDATA_WIDTH-1:0]  mem_q [pFIFO_DEPTH];
  logic [pDATA_WIDTH-1:0]  mem_d [pFIFO_DEPTH];

  logic                    res_ready_q, res_ready_d;
  logic                    tvalid_q, tvalid_d;
  logic [pDATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;
  logic                    finish_q, finish_d;
  logic                    busy_q, busy_d;

  logic                    wr_en;
  logic                    rd_en;
  logic                    empty_d;
  logic                    full_d;

  // Next-state: FSM, FIFO pointers/storage, counters, and the outputs they imply.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    wr_en     = res_valid & res_ready_q;
    rd_en     = tvalid_q & tready;

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          len_d     = data_length;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (data_length == '0) ? S_DONE : S_RUN;
        end
      end
      // len_q is never zero here; zero-length frames go straight to DONE
      S_RUN: begin
        if (rd_en && (out_cnt_q == len_q - pLEN_WIDTH'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = res_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
      in_cnt_d = in_cnt_q + pLEN_WIDTH'(1);
    end
    if (rd_en) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      out_cnt_d = out_cnt_q + pLEN_WIDTH'(1);
    end

    empty_d     = (wr_ptr_d == rd_ptr_d);
    full_d      = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    res_ready_d = (state_d == S_RUN) & ~full_d & (in_cnt_d != len_d);
    tvalid_d    = ~empty_d;
    tdata_d     = empty_d ? '0 : mem_d[rd_ptr_d[AW-1:0]];
    tlast_d     = ~empty_d & (len_d != '0) & (out_cnt_d == len_d - pLEN_WIDTH'(1));
    finish_d    = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
      res_ready_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      res_ready_q <= res_ready_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
    end
  end

  assign res_ready   = res_ready_q;
  assign tvalid      = tvalid_q;
  assign tdata       = tdata_q;
  assign tlast       = tlast_q;
  assign axis_finish = finish_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_axis_out.sv
// Scoreboard bench for axis_out: expected {tlast,tdata} pushed per frame,
// popped on every observed AXI-Stream handshake.
module tb_axis_out;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 32;

  typedef logic [DW:0] exp_t;

  logic          clk;
  logic          rst;
  logic          ap_start;
  logic [LW-1:0] data_length;
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tready;
  logic          axis_finish;
  logic          busy;

  exp_t exp_q[$];
  exp_t e;
  int   checks;
  int   errors;

  axis_out #(.pDATA_WIDTH(DW), .pFIFO_DEPTH(4), .pLEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .data_length(data_length),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .tvalid(tvalid), .tdata(tdata), .tlast(tlast), .tready(tready),
    .axis_finish(axis_finish), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: one-cycle ap_start pulse; returns at posedge+1 of the first RUN cycle.
  task automatic start_frame(input int len);
    ap_start    = 1'b1;
    data_length = LW'(len);
    @(posedge clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({tvalid, tlast, res_ready, axis_finish, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 00000", {tvalid, tlast, res_ready, axis_finish, busy});
    end
    checks++;
    if (tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0h, expected 0", tdata); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), DW'(5 + i)});
    start_frame(3);
    for (int k = 0; k < 7; k++) begin
      res_valid = (k < 3);
      res_data  = DW'(5 + k);
      tready    = 1'b1;
      @(negedge clk);
      checks++;
      if (tvalid !== 1'((k >= 1) && (k <= 3))) begin errors++; $display("FAIL basic_tvalid c%0d: got %b", k, tvalid); end
      checks++;
      if (axis_finish !== 1'(k == 4)) begin errors++; $display("FAIL basic_finish c%0d: got %b", k, axis_finish); end
      checks++;
      if (busy !== 1'(k <= 4)) begin errors++; $display("FAIL basic_busy c%0d: got %b", k, busy); end
      if (tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL basic_out: got %0h, expected nothing", {tlast, tdata}); end
        else begin
          e = exp_q.pop_front();
          if ({tlast, tdata} !== e) begin errors++; $display("FAIL basic_out: got %0h, expected %0h", {tlast, tdata}, e); end
        end
      end
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int nxt;
    int fin_cnt;
    exp_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back({(i == 8), DW'(i)});
    start_frame(8);
    nxt = 1; fin_cnt = 0;
    for (int k = 0; k < 22; k++) begin
      tready    = (k >= 6);
      res_valid = (nxt <= 8);
      res_data  = DW'(nxt);
      @(negedge clk);
      if (k < 6) begin
        checks++;
        if (res_ready !== 1'(k < 4)) begin errors++; $display("FAIL bp_res_ready c%0d: got %b, expected %b", k, res_ready, (k < 4)); end
        if (k >= 1) begin
          checks++;
          if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, 32'd1}) begin
            errors++; $display("FAIL bp_hold c%0d: got %0h, expected %0h", k, {tvalid, tlast, tdata}, {1'b1, 1'b0, 32'd1});
          end
        end
      end
      if (res_valid && res_ready) nxt++;
      if (axis_finish) fin_cnt++;
      if (tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_out: got %0h, expected nothing", {tlast, tdata}); end
        else begin
          e = exp_q.pop_front();
          if ({tlast, tdata} !== e) begin errors++; $display("FAIL bp_out: got %0h, expected %0h", {tlast, tdata}, e); end
        end
      end
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left: got %0d pending, expected 0", exp_q.size()); end
    checks++;
    if (nxt != 9) begin errors++; $display("FAIL bp_accepted: got %0d, expected 8", nxt - 1); end
    checks++;
    if (fin_cnt != 1) begin errors++; $display("FAIL bp_finish: got %0d pulses, expected 1", fin_cnt); end
  endtask

  task automatic test_zero_length();
    tready = 1'b1;
    ap_start = 1'b1;
    data_length = '0;
    @(negedge clk);
    checks++;
    if ({tvalid, axis_finish} !== 2'b00) begin errors++; $display("FAIL zero_c0: got %b, expected 00", {tvalid, axis_finish}); end
    @(posedge clk); #1;
    ap_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({tvalid, axis_finish, busy} !== 3'b011) begin errors++; $display("FAIL zero_c1: got %b, expected 011", {tvalid, axis_finish, busy}); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({tvalid, axis_finish, busy} !== 3'b000) begin errors++; $display("FAIL zero_c2: got %b, expected 000", {tvalid, axis_finish, busy}); end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    int nxt;
    int fin_cnt;
    exp_q.delete();
    exp_q.push_back({1'b0, 32'd10});
    exp_q.push_back({1'b1, 32'd11});
    start_frame(2);
    nxt = 10; fin_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tready    = 1'b1;
      res_valid = (nxt <= 12);
      res_data  = DW'(nxt);
      @(negedge clk);
      if (nxt == 12) begin
        checks++;
        if (res_ready !== 1'b0) begin errors++; $display("FAIL ovr_res_ready c%0d: got %b, expected 0", k, res_ready); end
      end
      if (res_valid && res_ready) nxt++;
      if (axis_finish) fin_cnt++;
      if (tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ovr_out: got %0h, expected nothing", {tlast, tdata}); end
        else begin
          e = exp_q.pop_front();
          if ({tlast, tdata} !== e) begin errors++; $display("FAIL ovr_out: got %0h, expected %0h", {tlast, tdata}, e); end
        end
      end
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
    checks++;
    if (nxt != 12) begin errors++; $display("FAIL ovr_accepted: got %0d, expected 2", nxt - 10); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ovr_left: got %0d pending, expected 0", exp_q.size()); end
    checks++;
    if (fin_cnt != 1) begin errors++; $display("FAIL ovr_finish: got %0d pulses, expected 1", fin_cnt); end
  endtask

  task automatic test_reset_mid();
    int fin_cnt;
    exp_q.delete();
    exp_q.push_back({1'b0, 32'd20});
    start_frame(4);
    tready = 1'b0; res_valid = 1'b1; res_data = 32'd20;
    @(posedge clk); #1;
    res_data = 32'd21;
    @(posedge clk); #1;
    res_valid = 1'b0; tready = 1'b1;
    @(negedge clk);
    checks++;
    if (!(tvalid && tready)) begin errors++; $display("FAIL rm_xfer: got tvalid %b, expected 1", tvalid); end
    else begin
      e = exp_q.pop_front();
      if ({tlast, tdata} !== e) begin errors++; $display("FAIL rm_xfer: got %0h, expected %0h", {tlast, tdata}, e); end
    end
    @(posedge clk); #1;
    tready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({tvalid, tlast, res_ready, busy, axis_finish} !== 5'b0) begin
      errors++; $display("FAIL rm_after: got %b, expected 00000", {tvalid, tlast, res_ready, busy, axis_finish});
    end
    checks++;
    if (tdata !== '0) begin errors++; $display("FAIL rm_tdata: got %0h, expected 0", tdata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({tvalid, axis_finish} !== 2'b00) begin errors++; $display("FAIL rm_quiet: got %b, expected 00", {tvalid, axis_finish}); end
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 32'd30});
    start_frame(1);
    fin_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      res_valid = (k == 0); res_data = 32'd30; tready = 1'b1;
      @(negedge clk);
      if (axis_finish) fin_cnt++;
      if (tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rm_new_out: got %0h, expected nothing", {tlast, tdata}); end
        else begin
          e = exp_q.pop_front();
          if ({tlast, tdata} !== e) begin errors++; $display("FAIL rm_new_out: got %0h, expected %0h", {tlast, tdata}, e); end
        end
      end
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || fin_cnt != 1) begin
      errors++; $display("FAIL rm_new_frame: got %0d pending %0d finish, expected 0 pending 1 finish", exp_q.size(), fin_cnt);
    end
  endtask

  task automatic test_spurious_start();
    int nxt;
    int hs;
    int fin_cnt;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), DW'(40 + i)});
    start_frame(3);
    nxt = 40; hs = 0; fin_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      ap_start    = (k == 1);
      data_length = LW'(9);
      res_valid   = (nxt <= 42);
      res_data    = DW'(nxt);
      tready      = 1'b1;
      @(negedge clk);
      if (res_valid && res_ready) nxt++;
      if (axis_finish) fin_cnt++;
      if (tvalid && tready) begin
        hs++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sp_out: got %0h, expected nothing", {tlast, tdata}); end
        else begin
          e = exp_q.pop_front();
          if ({tlast, tdata} !== e) begin errors++; $display("FAIL sp_out: got %0h, expected %0h", {tlast, tdata}, e); end
        end
      end
      @(posedge clk); #1;
    end
    ap_start = 1'b0; res_valid = 1'b0;
    checks++;
    if (hs != 3) begin errors++; $display("FAIL sp_count: got %0d transfers, expected 3", hs); end
    checks++;
    if (fin_cnt != 1) begin errors++; $display("FAIL sp_finish: got %0d pulses, expected 1", fin_cnt); end
    @(negedge clk);
    checks++;
    if ({busy, tvalid} !== 2'b00) begin errors++; $display("FAIL sp_idle: got %b, expected 00", {busy, tvalid}); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; ap_start = 1'b0; data_length = '0;
    res_data = '0; res_valid = 1'b0; tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_overrun();
    test_reset_mid();
    test_spurious_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
